c432_key_loader: RTL and testbench
==================================

Name: c432_key_loader

Overview:
- Sequential key-provisioning stage directly upstream of the locked c432 netlist.
- Receives the 44-bit unlock key serially (4 mux-select bits p1..p4, then 40 XOR key bits X_1..X_40), followed by an 8-bit CRC.
- Checks the CRC, then commits the key atomically to parallel outputs that drive the netlist key inputs.
- Holds the committed key stable; counts consecutive failures and locks out after too many.

Parameters:
- KEY_W, 44, total key bits (P_W + X_W).
- P_W, 4, mux-key bits; drive p1..p4.
- X_W, 40, XOR-key bits; drive X_1..X_40.
- CRC_W, 8, check bits following the key.
- CRC_POLY, 8'h07, CRC-8 polynomial; init 8'h00, no reflection, no final XOR.
- MAX_FAIL, 3, consecutive CRC failures that trigger lockout.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a new load session.
- key_bit  in  1  serial data bit.
- key_valid  in  1  key_bit is valid this cycle.
- key_ready  out  1  loader accepts a bit this cycle.
- key_p  out  P_W  committed mux key; key_p[i] drives p(i+1).
- key_x  out  X_W  committed XOR key; key_x[i] drives X_(i+1).
- key_ok  out  1  a committed, CRC-verified key is present.
- key_err  out  1  last session failed its CRC.
- locked_out  out  1  MAX_FAIL consecutive failures reached.
- busy  out  1  session in progress (SHIFT_KEY, SHIFT_CRC or CHECK).

Behaviour:
- Reset (async assert, sync deassert internally):
  - State goes to IDLE.
  - key_p, key_x, key_ok, key_err, locked_out, busy, key_ready all 0.
  - Shadow register, bit counter, CRC register and fail counter all 0.
- Transfer rule: a bit transfers on a rising edge where key_valid && key_ready. key_ready is a pure function of state.
- IDLE, DONE, ERR:
  - key_ready=0.
  - start=1 moves to SHIFT_KEY; counter and CRC clear, key_err clears, key_ok keeps its value.
- SHIFT_KEY:
  - key_ready=1.
  - First accepted bit is shadow[43] (p4), continuing down to shadow[0] (X_1). Packing: shadow[43:40] = p4..p1, shadow[39:0] = X_40..X_1.
  - Each accepted bit updates the CRC: fb = crc[7] ^ bit; crc = {crc[6:0],1'b0} ^ (fb ? CRC_POLY : 0).
  - After the 44th accept, go to SHIFT_CRC with the counter cleared.
- SHIFT_CRC:
  - key_ready=1; 8 bits are captured MSB first into rx_crc.
  - After the 8th accept, go to CHECK.
- CHECK (exactly one cycle, key_ready=0):
  - rx_crc == crc: key_p/key_x load from the shadow register on the next edge, key_ok=1, fail counter=0, go to DONE.
  - Mismatch: key outputs unchanged, key_ok unchanged, key_err=1, fail counter +1 (saturating). If it reaches MAX_FAIL, go to LOCKOUT; else go to ERR.
- LOCKOUT:
  - key_p, key_x and key_ok forced to 0; locked_out=1; key_ready=0.
  - start is ignored; only rst exits.
- Latency: key outputs update 2 edges after the last CRC bit is accepted (CHECK + commit).
- Boundary conditions:
  - key_valid low mid-session: the loader waits indefinitely, with no timeout.
  - start during SHIFT_KEY, SHIFT_CRC or CHECK aborts the session: return to the start of SHIFT_KEY, shadow/CRC/counter cleared, committed key untouched, fail counter unchanged.
  - start and a valid bit in the same cycle: start wins and the bit is dropped.
  - Committed outputs never change except at a successful commit, on LOCKOUT, or on reset; no partial key is ever visible.
  - rst mid-session: immediate return to the reset values, including clearing the committed key.

Decomposition:
- Package c432_key_pkg:
  - State enum: IDLE, SHIFT_KEY, SHIFT_CRC, CHECK, DONE, ERR, LOCKOUT.
  - Constants KEY_W, P_W, X_W, CRC_W, CRC_POLY.
  - Key-vector packing helpers.
- Sub-module crc8_serial: clear, enable, bit in; crc[7:0] out. Holds the per-bit CRC update only.
- The FSM, counters, shadow register and commit logic stay in the top module.

Test Plan:
1. Reset, then start; shift 44 zeros plus CRC 8'h00 with key_valid held high -> key_ok=1, key_p=0, key_x=0, key_err=0, commit exactly 2 cycles after the last CRC bit.
2. After case 1: start, shift a bench-model key with p=4'b1010 and a correct CRC -> key_p=4'b1010 and key_x matches the model; both stay stable throughout shifting and update only at commit.
3. Zero key with CRC 8'h01 -> key_err=1, key_ok and key outputs retain the previous key, state ERR.
4. Three consecutive bad-CRC sessions -> locked_out=1, key_p=0, key_x=0, key_ok=0; a further start pulse is ignored; rst clears locked_out.
5. Assert start after 20 bits of a session, then send a full valid load -> only the second session's key commits; a random key_valid gap pattern gives the same result.
6. Assert rst at bit 30 of a session -> all outputs 0 immediately (asynchronously); a subsequent full valid load succeeds.

Source files
------------

// File: rtl/c432_key_pkg.sv
// c432 key loader: shared constants, FSM states
// and key-vector packing helpers.
package c432_key_pkg;

  localparam int P_W      = 4;
  localparam int X_W      = 40;
  localparam int KEY_W    = P_W + X_W;
  localparam int CRC_W    = 8;
  localparam int MAX_FAIL = 3;
  localparam int CNT_W    = 6;
  localparam int FAIL_W   = 2;

  localparam logic [CRC_W-1:0] CRC_POLY = 8'h07;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_KEY,
    SHIFT_CRC,
    CHECK,
    DONE,
    ERR,
    LOCKOUT
  } state_t;

  // shadow[43:40] = p4..p1, shadow[39:0] = X_40..X_1
  function automatic logic [P_W-1:0] key_p_of(
    input logic [KEY_W-1:0] k
  );
    return k[KEY_W-1 -: P_W];
  endfunction

  function automatic logic [X_W-1:0] key_x_of(
    input logic [KEY_W-1:0] k
  );
    return k[X_W-1:0];
  endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8, MSB first, init 0,
// no reflection, no final XOR.
module crc8_serial
  import c432_key_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc
);

  logic fb;

  assign fb = crc[CRC_W-1] ^ bit_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= '0;
    end else if (clear) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[CRC_W-2:0], 1'b0}
           ^ (fb ? CRC_POLY : '0);
    end
  end

endmodule

// File: rtl/c432_key_loader.sv
// Serial key loader for the locked c432 netlist:
// shift, CRC check, atomic commit, lockout.
module c432_key_loader
  import c432_key_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           key_bit,
  input  logic           key_valid,
  output logic           key_ready,
  output logic [P_W-1:0] key_p,
  output logic [X_W-1:0] key_x,
  output logic           key_ok,
  output logic           key_err,
  output logic           locked_out,
  output logic           busy
);

  state_t state, state_n;

  logic [1:0]        rst_q;
  logic              rst_i;
  logic [KEY_W-1:0]  shadow;
  logic [CNT_W-1:0]  cnt;
  logic [CRC_W-1:0]  rx_crc;
  logic [CRC_W-1:0]  crc;
  logic [FAIL_W-1:0] fail_cnt;

  logic sess_clr;
  logic acc;
  logic commit;
  logic fail;
  logic lock_hit;

  // Async assert, synchronous release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_q <= 2'b11;
    else     rst_q <= {rst_q[0], 1'b0};
  end

  assign rst_i = rst_q[1];

  assign lock_hit =
    (fail_cnt == FAIL_W'(MAX_FAIL - 1));

  crc8_serial u_crc (
    .clk    (clk),
    .rst    (rst_i),
    .clear  (sess_clr),
    .en     (acc && state == SHIFT_KEY),
    .bit_in (key_bit),
    .crc    (crc)
  );

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    key_ready = 1'b0;
    busy      = 1'b0;
    sess_clr  = 1'b0;
    acc       = 1'b0;
    commit    = 1'b0;
    fail      = 1'b0;
    unique case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_n  = SHIFT_KEY;
          sess_clr = 1'b1;
        end
      end
      SHIFT_KEY: begin
        key_ready = 1'b1;
        busy      = 1'b1;
        if (start) begin
          sess_clr = 1'b1;
        end else if (key_valid) begin
          acc = 1'b1;
          if (cnt == CNT_W'(KEY_W - 1))
            state_n = SHIFT_CRC;
        end
      end
      SHIFT_CRC: begin
        key_ready = 1'b1;
        busy      = 1'b1;
        if (start) begin
          state_n  = SHIFT_KEY;
          sess_clr = 1'b1;
        end else if (key_valid) begin
          acc = 1'b1;
          if (cnt == CNT_W'(CRC_W - 1))
            state_n = CHECK;
        end
      end
      CHECK: begin
        busy = 1'b1;
        if (start) begin
          state_n  = SHIFT_KEY;
          sess_clr = 1'b1;
        end else if (rx_crc == crc) begin
          commit  = 1'b1;
          state_n = DONE;
        end else begin
          fail    = 1'b1;
          state_n = lock_hit ? LOCKOUT : ERR;
        end
      end
      LOCKOUT: ;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      shadow     <= '0;
      cnt        <= '0;
      rx_crc     <= '0;
      fail_cnt   <= '0;
      key_p      <= '0;
      key_x      <= '0;
      key_ok     <= 1'b0;
      key_err    <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      if (sess_clr) begin
        shadow  <= '0;
        cnt     <= '0;
        rx_crc  <= '0;
        key_err <= 1'b0;
      end else if (acc) begin
        if (state == SHIFT_KEY) begin
          shadow <= {shadow[KEY_W-2:0], key_bit};
          cnt    <= (cnt == CNT_W'(KEY_W - 1))
                  ? '0 : cnt + 1'b1;
        end else begin
          rx_crc <= {rx_crc[CRC_W-2:0], key_bit};
          cnt    <= cnt + 1'b1;
        end
      end
      if (commit) begin
        key_p    <= key_p_of(shadow);
        key_x    <= key_x_of(shadow);
        key_ok   <= 1'b1;
        fail_cnt <= '0;
      end
      if (fail) begin
        key_err <= 1'b1;
        if (fail_cnt != FAIL_W'(MAX_FAIL))
          fail_cnt <= fail_cnt + 1'b1;
        if (lock_hit) begin
          key_p      <= '0;
          key_x      <= '0;
          key_ok     <= 1'b0;
          locked_out <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_c432_key_loader.sv
// Self-checking bench for c432_key_loader:
// vector table, hand sequences, random sessions.
module tb_c432_key_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        key_bit = 1'b0;
  logic        key_valid = 1'b0;
  logic        key_ready;
  logic [3:0]  key_p;
  logic [39:0] key_x;
  logic        key_ok;
  logic        key_err;
  logic        locked_out;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int unstable = 0;
  logic [44:0] pre;

  // model of committed state
  logic [43:0] m_key;
  logic        m_ok, m_err, m_lock;
  int          m_fails;

  typedef struct {
    logic [43:0] key;
    logic [7:0]  crc_xor;
    logic [43:0] exp_key;
    logic        exp_ok;
    logic        exp_err;
    logic        exp_lock;
  } vec_t;

  vec_t tbl[5];

  c432_key_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key_bit    (key_bit),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_p      (key_p),
    .key_x      (key_x),
    .key_ok     (key_ok),
    .key_err    (key_err),
    .locked_out (locked_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // CRC as remainder of M(x)*x^8 mod x^8+x^2+x+1
  function automatic logic [7:0] ref_crc(
    input logic [43:0] k
  );
    logic [51:0] m;
    m = {k, 8'h00};
    for (int i = 51; i >= 8; i--)
      if (m[i]) m[i -: 9] = m[i -: 9] ^ 9'h107;
    return m[7:0];
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_key = '0; m_ok = 0; m_err = 0;
    m_lock = 0; m_fails = 0;
  endtask

  task automatic model_session(input logic [43:0] k,
                               input logic [7:0] c);
    if (c == ref_crc(k)) begin
      m_key = k; m_ok = 1; m_err = 0; m_fails = 0;
    end else begin
      m_err = 1;
      m_fails++;
      if (m_fails >= 3) begin
        m_lock = 1; m_key = '0; m_ok = 0;
      end
    end
  endtask

  task automatic cmp_out(input string nm,
                         input logic [43:0] ek,
                         input logic eo,
                         input logic ee,
                         input logic el);
    chk({nm, "_p"}, key_p, ek[43:40]);
    chk({nm, "_x"}, key_x, ek[39:0]);
    chk({nm, "_flags"},
        {key_ok, key_err, locked_out, busy},
        {eo, ee, el, 1'b0});
  endtask

  task automatic cmp_model(input string nm);
    cmp_out(nm, m_key, m_ok, m_err, m_lock);
  endtask

  task automatic note_stable();
    if ({key_p, key_x, key_ok} !== pre) unstable++;
  endtask

  task automatic begin_pre();
    pre = {key_p, key_x, key_ok};
    unstable = 0;
  endtask

  // called at a negedge; returns at a negedge
  task automatic pulse_start(input logic with_bit);
    start = 1'b1;
    key_valid = with_bit;
    key_bit = 1'b1;
    @(negedge clk);
    start = 1'b0;
    key_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [51:0] s,
                           input int n,
                           input int gap);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < 6; g++) begin
        if ($urandom_range(99) >= gap) break;
        key_valid = 1'b0;
        @(negedge clk);
        note_stable();
      end
      key_valid = 1'b1;
      key_bit = s[51-i];
      @(negedge clk);
      note_stable();
    end
    key_valid = 1'b0;
  endtask

  // at the CHECK-cycle negedge; steps to commit
  task automatic finish_session(input string nm);
    chk({nm, "_stable"}, unstable, 0);
    chk({nm, "_check"}, {key_ready, busy}, 2'b01);
    @(negedge clk);
  endtask

  task automatic session(input string nm,
                         input logic [43:0] k,
                         input logic [7:0] c,
                         input int gap);
    begin_pre();
    pulse_start(1'b0);
    send_bits({k, c}, 52, gap);
    finish_session(nm);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
  endtask

  logic [43:0] k1, ka, kb, kr;
  logic [7:0]  cr;

  initial begin
    k1 = {4'b1010, 40'h12_3456_789A};
    tbl[0] = '{44'h0, 8'h00, 44'h0, 1, 0, 0};
    tbl[1] = '{k1, 8'h00, k1, 1, 0, 0};
    tbl[2] = '{44'h0, 8'h01, k1, 1, 1, 0};
    tbl[3] = '{44'hA5A_5A5A_5A5A, 8'h80, k1, 1, 1, 0};
    tbl[4] = '{44'h0, 8'h01, 44'h0, 0, 1, 1};

    repeat (2) @(negedge clk);
    cmp_out("reset", 44'h0, 0, 0, 0);
    chk("reset_ready", key_ready, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();

    for (int i = 0; i < 5; i++) begin
      session($sformatf("vec%0d", i), tbl[i].key,
              ref_crc(tbl[i].key) ^ tbl[i].crc_xor, 0);
      cmp_out($sformatf("vec%0d", i), tbl[i].exp_key,
              tbl[i].exp_ok, tbl[i].exp_err,
              tbl[i].exp_lock);
    end

    // lockout ignores start and data
    begin_pre();
    pulse_start(1'b0);
    send_bits({k1, ref_crc(k1)}, 52, 0);
    repeat (2) @(negedge clk);
    chk("lock_ignore_start",
        {key_ready, busy, locked_out}, 3'b001);
    chk("lock_hold", unstable, 0);
    do_reset();
    cmp_model("lock_rst");

    // abort after 20 bits; start+bit: bit dropped
    for (int r = 0; r < 2; r++) begin
      ka = {$urandom, $urandom};
      kb = {$urandom, $urandom};
      begin_pre();
      pulse_start(1'b0);
      send_bits({ka, ref_crc(ka)}, 20, r * 40);
      pulse_start(1'b1);
      send_bits({kb, ref_crc(kb)}, 52, r * 40);
      finish_session($sformatf("abort%0d", r));
      model_session(kb, ref_crc(kb));
      cmp_model($sformatf("abort%0d", r));
    end

    // async reset at bit 30
    ka = {$urandom, $urandom};
    begin_pre();
    pulse_start(1'b0);
    send_bits({ka, ref_crc(ka)}, 30, 0);
    #2 rst = 1'b1;
    #1;
    cmp_out("async_rst", 44'h0, 0, 0, 0);
    chk("async_rst_ready", key_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    session("post_rst", ka, ref_crc(ka), 0);
    model_session(ka, ref_crc(ka));
    cmp_model("post_rst");

    // random sessions vs model
    for (int n = 0; n < 16; n++) begin
      if (m_lock) do_reset();
      kr = {$urandom, $urandom};
      cr = ref_crc(kr);
      if ($urandom_range(2) == 0)
        cr = cr ^ 8'($urandom_range(1, 255));
      session($sformatf("rnd%0d", n), kr, cr, 30);
      model_session(kr, cr);
      cmp_model($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
